// File: rtl/fifo_mon_pkg.sv
// Shared types for the FIFO overflow/underflow monitor.
package fifo_mon_pkg;

    // Kind of error held in the capture record.
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_UDF  = 2'b10
    } err_kind_t;

    // Capture FSM: IDLE waits for the first event, HELD freezes the record.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } cap_state_t;

endpackage : fifo_mon_pkg

// File: rtl/fifo_mon_ch.sv
// Per-channel monitor: overflow/underflow detection, sticky flags and
// high-water mark of the FIFO occupancy.
module fifo_mon_ch
    import fifo_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [CW-1:0] count,
    output logic          ovf_evt,
    output logic          udf_evt,
    output logic          ovf_sticky,
    output logic          udf_sticky,
    output logic [CW-1:0] hwm
);

    // Event detection; a push paired with a pop at full is a pass-through, not an overflow.
    always_comb begin
        ovf_evt = push && !pop && (count == CW'(FIFO_DEPTH));
        udf_evt = pop && (count == '0);
    end

    // Sticky flags and high-water mark; clr drops this cycle's events.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset || clr) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
            hwm        <= '0;
        end else begin
            if (ovf_evt) ovf_sticky <= 1'b1;
            if (udf_evt) udf_sticky <= 1'b1;
            if (count > hwm) hwm <= count;
        end
    end

endmodule : fifo_mon_ch

// File: rtl/fifo_ovf_monitor.sv
// Monitor for NUM_CH FIFOs: per-channel stickies and high-water marks,
// saturating event totals and a single-entry first-error capture record.
module fifo_ovf_monitor
    import fifo_mon_pkg::*;
#(
    parameter int NUM_CH     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int PCKG_SZ    = 40,
    parameter int TOT_W      = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CH-1:0]                           push,
    input  logic [NUM_CH-1:0]                           pop,
    input  logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    count,
    input  logic [NUM_CH*PCKG_SZ-1:0]                   din,
    input  logic                                        clr,
    input  logic                                        err_ack,
    output logic [NUM_CH-1:0]                           ovf_sticky,
    output logic [NUM_CH-1:0]                           udf_sticky,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    hwm,
    output logic                                        err_valid,
    output logic [$clog2(NUM_CH)-1:0]                   err_ch,
    output logic [1:0]                                  err_kind,
    output logic [PCKG_SZ-1:0]                          err_data,
    output logic                                        err_lost,
    output logic [TOT_W-1:0]                            ovf_total,
    output logic [TOT_W-1:0]                            udf_total,
    output logic                                        irq
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CHW   = $clog2(NUM_CH);
    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((TOT_W > PC_W) ? TOT_W : PC_W) + 1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [NUM_CH-1:0] ovf_evt;
    logic [NUM_CH-1:0] udf_evt;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            fifo_mon_ch #(
                .FIFO_DEPTH (FIFO_DEPTH),
                .CW         (CW)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .clr        (clr),
                .push       (push[g]),
                .pop        (pop[g]),
                .count      (count[g*CW +: CW]),
                .ovf_evt    (ovf_evt[g]),
                .udf_evt    (udf_evt[g]),
                .ovf_sticky (ovf_sticky[g]),
                .udf_sticky (udf_sticky[g]),
                .hwm        (hwm[g*CW +: CW])
            );
        end
    endgenerate

    logic             evt_any;
    logic [CHW-1:0]   sel_ch;
    err_kind_t        sel_kind;
    logic [PCKG_SZ-1:0] sel_data;

    // Priority encoder: scan downward so the lowest event channel wins; overflow beats underflow.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        evt_any  = 1'b0;
        sel_ch   = '0;
        sel_kind = ERR_NONE;
        sel_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ovf_evt[i] || udf_evt[i]) begin
                evt_any = 1'b1;
                sel_ch  = CHW'(i);
                if (ovf_evt[i]) begin
                    sel_kind = ERR_OVF;
                    sel_data = din[i*PCKG_SZ +: PCKG_SZ];
                end else begin
                    sel_kind = ERR_UDF;
                    sel_data = '0;
                end
            end
        end
    end

    logic [PC_W-1:0]  ovf_cnt, udf_cnt;
    logic [SUM_W-1:0] ovf_sum, udf_sum;
    logic [TOT_W-1:0] ovf_next, udf_next;

    // Popcount of this cycle's events and saturating next totals.
    always_comb begin
        ovf_cnt = '0;
        udf_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ovf_cnt = ovf_cnt + PC_W'(ovf_evt[i]);
            udf_cnt = udf_cnt + PC_W'(udf_evt[i]);
        end
        ovf_sum  = SUM_W'(ovf_total) + SUM_W'(ovf_cnt);
        udf_sum  = SUM_W'(udf_total) + SUM_W'(udf_cnt);
        ovf_next = (ovf_sum > SUM_W'(TOT_MAX)) ? TOT_MAX : ovf_sum[TOT_W-1:0];
        udf_next = (udf_sum > SUM_W'(TOT_MAX)) ? TOT_MAX : udf_sum[TOT_W-1:0];
    end

    // Event totals.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ovf_total <= '0;
            udf_total <= '0;
        end else begin
            ovf_total <= ovf_next;
            udf_total <= udf_next;
        end
    end

    cap_state_t state;
    err_kind_t  err_kind_q;

    // Capture FSM with registered record outputs; reset outranks clr, clr outranks events.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state      <= ST_IDLE;
            err_valid  <= 1'b0;
            err_ch     <= '0;
            err_kind_q <= ERR_NONE;
            err_data   <= '0;
            err_lost   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt_any) begin
                        state      <= ST_HELD;
                        err_valid  <= 1'b1;
                        err_ch     <= sel_ch;
                        err_kind_q <= sel_kind;
                        err_data   <= sel_data;
                    end
                end
                ST_HELD: begin
                    if (evt_any) err_lost <= 1'b1;
                    if (err_ack) begin
                        state     <= ST_IDLE;
                        err_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign err_kind = err_kind_q;

    // Interrupt from sticky registers only.
    assign irq = (|ovf_sticky) | (|udf_sticky);

endmodule : fifo_ovf_monitor

// File: tb/tb_fifo_ovf_monitor.sv
// Directed self-checking bench for fifo_ovf_monitor with an expectation queue.
module tb_fifo_ovf_monitor;

    localparam int NUM_CH = 64;
    localparam int DEPTH  = 4;
    localparam int PK     = 40;
    localparam int TW     = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_CH-1:0]      push, pop;
    logic [NUM_CH*CW-1:0]   count;
    logic [NUM_CH*PK-1:0]   din;
    logic                   clr, err_ack;
    logic [NUM_CH-1:0]      ovf_sticky, udf_sticky;
    logic [NUM_CH*CW-1:0]   hwm;
    logic                   err_valid;
    logic [5:0]             err_ch;
    logic [1:0]             err_kind;
    logic [PK-1:0]          err_data;
    logic                   err_lost;
    logic [TW-1:0]          ovf_total, udf_total;
    logic                   irq;

    fifo_ovf_monitor #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .PCKG_SZ(PK), .TOT_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .count(count),
        .din(din), .clr(clr), .err_ack(err_ack),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .hwm(hwm),
        .err_valid(err_valid), .err_ch(err_ch), .err_kind(err_kind),
        .err_data(err_data), .err_lost(err_lost),
        .ovf_total(ovf_total), .udf_total(udf_total), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef enum {O_OVFV, O_UDFV, O_HWM, O_VALID, O_CH, O_KIND, O_DATA,
                  O_LOST, O_OVFT, O_UDFT, O_IRQ} obs_t;
    typedef struct {
        string       tag;
        obs_t        what;
        int          ch;
        logic [63:0] exp;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] observe(obs_t w, int ch);
        case (w)
            O_OVFV:  return 64'(ovf_sticky);
            O_UDFV:  return 64'(udf_sticky);
            O_HWM:   return 64'(hwm[ch*CW +: CW]);
            O_VALID: return 64'(err_valid);
            O_CH:    return 64'(err_ch);
            O_KIND:  return 64'(err_kind);
            O_DATA:  return 64'(err_data);
            O_LOST:  return 64'(err_lost);
            O_OVFT:  return 64'(ovf_total);
            O_UDFT:  return 64'(udf_total);
            O_IRQ:   return 64'(irq);
            default: return 64'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(string tag, obs_t what, int ch, logic [63:0] exp);
        item_t it;
        it.tag = tag; it.what = what; it.ch = ch; it.exp = exp;
        sb.push_back(it);
    endtask

    // One clock edge, then compare every pending expectation against the DUT.
    task automatic step();
        item_t it;
        logic [63:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.what, it.ch);
            total++;
            assert (obs === it.exp) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic clear_in();
        push = '0; pop = '0; count = '0; din = '0;
    endtask

    task automatic set_ch(int ch, int cnt, logic ps, logic pp, logic [PK-1:0] d);
        count[ch*CW +: CW] = CW'(cnt);
        push[ch] = ps;
        pop[ch]  = pp;
        din[ch*PK +: PK] = d;
    endtask

    task automatic expect_all_zero(string tag);
        expect_val({tag, "_ovfv"},  O_OVFV,  0, 64'h0);
        expect_val({tag, "_udfv"},  O_UDFV,  0, 64'h0);
        expect_val({tag, "_valid"}, O_VALID, 0, 64'h0);
        expect_val({tag, "_ch"},    O_CH,    0, 64'h0);
        expect_val({tag, "_kind"},  O_KIND,  0, 64'h0);
        expect_val({tag, "_data"},  O_DATA,  0, 64'h0);
        expect_val({tag, "_lost"},  O_LOST,  0, 64'h0);
        expect_val({tag, "_ovft"},  O_OVFT,  0, 64'h0);
        expect_val({tag, "_udft"},  O_UDFT,  0, 64'h0);
        expect_val({tag, "_irq"},   O_IRQ,   0, 64'h0);
        expect_val({tag, "_hwm0"},  O_HWM,   0, 64'h0);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; err_ack = 1'b0;
        clear_in();
        step();
        expect_all_zero("reset");
        step();
        reset = 1'b0;

        // Single overflow on ch 5.
        set_ch(5, 4, 1'b1, 1'b0, 40'hAB_CDEF_0123);
        expect_val("ovf5_sticky", O_OVFV,  0, 64'h1 << 5);
        expect_val("ovf5_valid",  O_VALID, 0, 64'h1);
        expect_val("ovf5_ch",     O_CH,    0, 64'd5);
        expect_val("ovf5_kind",   O_KIND,  0, 64'h1);
        expect_val("ovf5_data",   O_DATA,  0, 64'hAB_CDEF_0123);
        expect_val("ovf5_total",  O_OVFT,  0, 64'h1);
        expect_val("ovf5_irq",    O_IRQ,   0, 64'h1);
        step();
        clear_in();
        err_ack = 1'b1;
        expect_val("ack_valid", O_VALID, 0, 64'h0);
        expect_val("ack_hwm5",  O_HWM,   5, 64'd4);
        step();
        err_ack = 1'b0;
        clr = 1'b1;
        expect_all_zero("clr1");
        expect_val("clr1_hwm5", O_HWM, 5, 64'h0);
        step();
        clr = 1'b0;

        // Push with pop at full is not overflow; then underflow on ch 3.
        set_ch(3, 4, 1'b1, 1'b1, 40'h12);
        expect_val("pp_ovfv",  O_OVFV,  0, 64'h0);
        expect_val("pp_ovft",  O_OVFT,  0, 64'h0);
        expect_val("pp_valid", O_VALID, 0, 64'h0);
        step();
        clear_in();
        set_ch(3, 0, 1'b1, 1'b1, 40'h55);
        expect_val("udf3_udfv",  O_UDFV,  0, 64'h1 << 3);
        expect_val("udf3_kind",  O_KIND,  0, 64'h2);
        expect_val("udf3_data",  O_DATA,  0, 64'h0);
        expect_val("udf3_ch",    O_CH,    0, 64'd3);
        expect_val("udf3_udft",  O_UDFT,  0, 64'h1);
        expect_val("udf3_ovft",  O_OVFT,  0, 64'h0);
        step();
        clear_in();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Mixed: underflow on ch 6 beats overflow on ch 10 by index.
        set_ch(6, 0, 1'b0, 1'b1, 40'h0);
        set_ch(10, 4, 1'b1, 1'b0, 40'hA);
        expect_val("mix_ch",   O_CH,   0, 64'd6);
        expect_val("mix_kind", O_KIND, 0, 64'h2);
        step();
        clear_in();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Three overflows on one edge: lowest index captured.
        set_ch(9,  4, 1'b1, 1'b0, 40'h99_9999_9999);
        set_ch(2,  4, 1'b1, 1'b0, 40'h22_2222_2222);
        set_ch(40, 4, 1'b1, 1'b0, 40'h40_4040_4040);
        expect_val("tri_ch",   O_CH,   0, 64'd2);
        expect_val("tri_ovft", O_OVFT, 0, 64'd3);
        expect_val("tri_data", O_DATA, 0, 64'h22_2222_2222);
        step();

        // While HELD: new event sets err_lost, record frozen.
        clear_in();
        set_ch(7, 4, 1'b1, 1'b0, 40'h77);
        expect_val("held_lost",  O_LOST,  0, 64'h1);
        expect_val("held_ch",    O_CH,    0, 64'd2);
        expect_val("held_data",  O_DATA,  0, 64'h22_2222_2222);
        expect_val("held_valid", O_VALID, 0, 64'h1);
        step();
        // Event in the ack cycle is counted but not captured.
        clear_in();
        set_ch(12, 4, 1'b1, 1'b0, 40'hC);
        err_ack = 1'b1;
        expect_val("ackev_valid", O_VALID, 0, 64'h0);
        expect_val("ackev_ovft",  O_OVFT,  0, 64'd5);
        step();
        // Ack while IDLE is ignored.
        clear_in();
        expect_val("idle_valid", O_VALID, 0, 64'h0);
        step();
        err_ack = 1'b0;
        set_ch(1, 4, 1'b1, 1'b0, 40'h11);
        expect_val("cap1_valid", O_VALID, 0, 64'h1);
        expect_val("cap1_ch",    O_CH,    0, 64'd1);
        expect_val("cap1_ovft",  O_OVFT,  0, 64'd6);
        expect_val("cap1_lost",  O_LOST,  0, 64'h1);
        step();
        clear_in();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Drive ovf_total to 0xFFFE, then saturate.
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 4, 1'b1, 1'b0, 40'h0);
        repeat (1023) step();
        clear_in();
        for (int c = 0; c < 62; c++) set_ch(c, 4, 1'b1, 1'b0, 40'h0);
        expect_val("pre_ovft", O_OVFT, 0, 64'hFFFE);
        step();
        clear_in();
        for (int c = 0; c < 3; c++) set_ch(c, 4, 1'b1, 1'b0, 40'h0);
        expect_val("sat_ovft", O_OVFT, 0, 64'hFFFF);
        step();
        clear_in();
        set_ch(4, 4, 1'b1, 1'b0, 40'h0);
        expect_val("nowrap_ovft", O_OVFT, 0, 64'hFFFF);
        step();
        // clr beats a same-edge overflow.
        clear_in();
        set_ch(0, 4, 1'b1, 1'b0, 40'hFF);
        clr = 1'b1;
        expect_all_zero("clr_ovf");
        step();
        clr = 1'b0;
        clear_in();

        // High-water mark tracking on ch 0.
        set_ch(0, 1, 1'b0, 1'b0, 40'h0);
        expect_val("hwm_a", O_HWM, 0, 64'd1);
        step();
        set_ch(0, 3, 1'b0, 1'b0, 40'h0);
        expect_val("hwm_b", O_HWM, 0, 64'd3);
        step();
        set_ch(0, 2, 1'b0, 1'b0, 40'h0);
        expect_val("hwm_c", O_HWM, 0, 64'd3);
        step();
        set_ch(0, 4, 1'b0, 1'b0, 40'h0);
        expect_val("hwm_d", O_HWM, 0, 64'd4);
        step();
        set_ch(0, 0, 1'b0, 1'b0, 40'h0);
        expect_val("hwm_e", O_HWM, 0, 64'd4);
        step();

        // Reset in the middle of HELD discards everything.
        set_ch(5, 4, 1'b1, 1'b0, 40'h5);
        expect_val("pre_rst_valid", O_VALID, 0, 64'h1);
        step();
        clear_in();
        reset = 1'b1; clr = 1'b1; err_ack = 1'b1;
        set_ch(8, 4, 1'b1, 1'b0, 40'h8);
        expect_all_zero("rst_held");
        step();
        reset = 1'b0; clr = 1'b0; err_ack = 1'b0;
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_ovf_monitor
